// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin scheduler that shares one RSA_decrypt core among
// N requesters. It accepts one (c, d, n) job at a time, pulses core_start for one
// cycle, captures core_m on core_finish and returns it tagged with the requester ID.
//
// Optional constant-latency mode, enabled by defining RSA_ARB_CONST_TIME_EN:
// every response is held back until PAD_CYCLES+1 cycles after core_start, hiding
// the data-dependent run time of the core. A core slower than PAD_CYCLES is
// reported through rsp_overrun.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    per-requester request / one-hot accept pulse (same cycle)
//   req_c/d/n          N*W packed operands, requester i at [i*W +: W]
//   rsp_valid/ready    result handshake
//   rsp_id/m/lat       owner index, decrypted message, true core latency (saturating)
//   rsp_overrun        core exceeded PAD_CYCLES (constant-latency mode only)
//   core_start/c/d/n   one-cycle launch pulse and operands to the core (0 otherwise)
//   core_m/finish      core result and done pulse
module rsa_job_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 16,
  parameter int unsigned CW         = 20,
  parameter int unsigned PAD_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*W-1:0]         req_c,
  input  logic [N*W-1:0]         req_d,
  input  logic [N*W-1:0]         req_n,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [W-1:0]           rsp_m,
  output logic [CW-1:0]          rsp_lat,
  output logic                   rsp_overrun,
  output logic                   core_start,
  output logic [W-1:0]           core_c,
  output logic [W-1:0]           core_d,
  output logic [W-1:0]           core_n,
  input  logic [W-1:0]           core_m,
  input  logic                   core_finish
);

  localparam int unsigned IDW = $clog2(N);
  localparam logic [CW-1:0] PAD_LIM = CW'(PAD_CYCLES);
`ifdef RSA_ARB_CONST_TIME_EN
  localparam bit CONST_EN = 1'b1;
`else
  localparam bit CONST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_PAD,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            armed_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rsp_m_q, rsp_m_d;
  logic [CW-1:0]   rsp_lat_q, rsp_lat_d;
  logic            ovr_q, ovr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            core_start_q, core_start_d;
  logic [W-1:0]    core_c_q, core_c_d;
  logic [W-1:0]    core_d_q, core_d_d;
  logic [W-1:0]    core_n_q, core_n_d;

  // Round-robin search: rotate requests so ptr sits at bit 0, take the lowest set bit.
  logic [2*N-1:0]  rot_dbl;
  logic [N-1:0]    rot;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_off;
  logic [IDW:0]    gnt_sum;
  logic [IDW-1:0]  gnt_idx;

  always_comb begin
    rot_dbl = {req_valid, req_valid} >> ptr_q;
    rot     = rot_dbl[N-1:0];
    gnt_vld = |rot;
    gnt_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) gnt_off = IDW'(k);
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
    gnt_idx = (gnt_sum >= (IDW+1)'(N)) ? IDW'(gnt_sum - (IDW+1)'(N)) : IDW'(gnt_sum);
  end

  // Saturating latency counter increment.
  logic [CW-1:0] cnt_inc;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rsp_m_d      = rsp_m_q;
    rsp_lat_d    = rsp_lat_q;
    ovr_d        = ovr_q;
    core_start_d = 1'b0;
    core_c_d     = '0;
    core_d_d     = '0;
    core_n_d     = '0;
    req_ready    = '0;

    case (state_q)
      S_IDLE: begin
        // armed_q blocks an accept in the first cycle out of reset.
        if (armed_q && gnt_vld && !rst) begin
          req_ready    = N'(1) << gnt_idx;
          id_d         = gnt_idx;
          core_start_d = 1'b1;
          core_c_d     = req_c[32'(gnt_idx) * W +: W];
          core_d_d     = req_d[32'(gnt_idx) * W +: W];
          core_n_d     = req_n[32'(gnt_idx) * W +: W];
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (core_finish) begin
          rsp_m_d   = core_m;
          rsp_lat_d = cnt_inc;
          ovr_d     = 1'b0;
          if (!CONST_EN) begin
            state_d = S_RESP;
          end else if (cnt_inc >= PAD_LIM) begin
            // Core already used up the padding window: release at once.
            state_d = S_RESP;
            ovr_d   = (cnt_inc > PAD_LIM);
          end else begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= PAD_LIM) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      ptr_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      rsp_m_q      <= '0;
      rsp_lat_q    <= '0;
      ovr_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_c_q     <= '0;
      core_d_q     <= '0;
      core_n_q     <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rsp_m_q      <= rsp_m_d;
      rsp_lat_q    <= rsp_lat_d;
      ovr_q        <= ovr_d;
      rsp_valid_q  <= rsp_valid_d;
      core_start_q <= core_start_d;
      core_c_q     <= core_c_d;
      core_d_q     <= core_d_d;
      core_n_q     <= core_n_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_m       = rsp_m_q;
  assign rsp_lat     = rsp_lat_q;
  assign rsp_overrun = ovr_q;
  assign core_start  = core_start_q;
  assign core_c      = core_c_q;
  assign core_d      = core_d_q;
  assign core_n      = core_n_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Testbench for rsa_job_arbiter: randomized requesters and a behavioural core,
// checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_rsa_job_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 20;
`ifdef RSA_ARB_CONST_TIME_EN
  localparam bit          CT  = 1'b1;
  localparam int unsigned PAD = 40;
  localparam int unsigned LAT_MAX = 60;
`else
  localparam bit          CT  = 1'b0;
  localparam int unsigned PAD = 200000;
  localparam int unsigned LAT_MAX = 30;
`endif
  localparam int unsigned IDW   = $clog2(N);
  localparam int          NEVER = 32'h3fff_ffff;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*W-1:0]       req_c = '0, req_d = '0, req_n = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_m;
  logic [CW-1:0]        rsp_lat;
  logic                 rsp_overrun;
  logic                 core_start;
  logic [W-1:0]         core_c, core_d, core_n;
  logic [W-1:0]         core_m = '0;
  logic                 core_finish = 1'b0;

  rsa_job_arbiter #(.N(N), .W(W), .CW(CW), .PAD_CYCLES(PAD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_c(req_c), .req_d(req_d), .req_n(req_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_m(rsp_m), .rsp_lat(rsp_lat), .rsp_overrun(rsp_overrun),
    .core_start(core_start), .core_c(core_c), .core_d(core_d), .core_n(core_n),
    .core_m(core_m), .core_finish(core_finish)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Plain square-and-multiply reference for c^d mod n.
  function automatic logic [W-1:0] modexp(input logic [W-1:0] c, input logic [W-1:0] d,
                                          input logic [W-1:0] n);
    longint unsigned r, b, e, nn;
    nn = longint'(n);
    r  = 1 % nn;
    b  = longint'(c) % nn;
    e  = longint'(d);
    while (e != 0) begin
      if ((e & 1) != 0) r = (r * b) % nn;
      b = (b * b) % nn;
      e = e >> 1;
    end
    return W'(r);
  endfunction

  // First requester at or after p, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
    end
    return -1;
  endfunction

  // Requester side
  logic [N-1:0] rq_v = '0;
  logic [W-1:0] rq_c [N];
  logic [W-1:0] rq_d [N];
  logic [W-1:0] rq_n [N];

  // Reference model of the job in flight
  bit          job_act = 1'b0;
  int          job_id, job_L, job_lat;
  int          job_rise = NEVER;
  bit          job_ovr;
  logic [W-1:0] job_c, job_d, job_n;
  int          m_ptr = 0;
  bit          rst_prev;
  bit          rst_next = 1'b1;
  bit          exp_rv;

  // Behavioural core
  bit          fin_pend = 1'b0;
  int          fin_cyc;
  logic [W-1:0] fin_m;
  int          lat_force = 0;

  int          bp_cnt = 0;
  int          dut_hs = 0;
  int          mod_hs = 0;
  logic [N-1:0] dut_log [$];

  task automatic set_req(input int i, input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [W-1:0] n);
    rq_c[i] = c;
    rq_d[i] = d;
    rq_n[i] = n;
    rq_v[i] = 1'b1;
  endtask

  task automatic set_rand_req(input int i);
    logic [W-1:0] n;
    n = W'($urandom_range(3, 65535));
    set_req(i, W'($urandom_range(0, int'(n) - 1)), W'($urandom), n);
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge, update model.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    bit exp_cs;
    int lat;
    @(posedge clk);
    rst_prev = rst;
    cyc++;
    #1;
    rst = rst_next;
    core_finish = fin_pend && (cyc == fin_cyc);
    core_m = core_finish ? fin_m : W'($urandom);
    if (core_finish) fin_pend = 1'b0;
    req_valid = rq_v;
    for (int i = 0; i < N; i++) begin
      req_c[i*W +: W] = rq_c[i];
      req_d[i*W +: W] = rq_d[i];
      req_n[i*W +: W] = rq_n[i];
    end
    exp_rv = job_act && (cyc >= job_rise);
    if (exp_rv && bp_cnt > 0) begin
      rsp_ready = 1'b0;
      bp_cnt--;
    end else begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (!rst && !rst_prev && !job_act) begin
      g = pick(rq_v, m_ptr);
      if (g >= 0) exp_rdy = N'(1) << g;
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_cs = job_act && (cyc == job_L);
    check("core_start", 64'(core_start), 64'(exp_cs));
    check("core_ops", 64'({core_c, core_d, core_n}),
          exp_cs ? 64'({job_c, job_d, job_n}) : 64'(0));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (rst_prev) begin
      check("rst_rsp_zero", 64'({rsp_id, rsp_m, rsp_lat, rsp_overrun}), 64'(0));
    end
    if (exp_rv) begin
      check("rsp_id", 64'(rsp_id), 64'(job_id));
      check("rsp_m", 64'(rsp_m), 64'(modexp(job_c, job_d, job_n)));
      check("rsp_lat", 64'(rsp_lat), 64'(job_lat));
      check("rsp_overrun", 64'(rsp_overrun), 64'(job_ovr));
      if (rsp_ready && job_c == 16'd1394 && job_d == 16'd2011 && job_n == 16'd3127)
        check("kat_89", 64'(rsp_m), 64'd89);
      if (rsp_ready && job_c == 16'd8 && job_d == 16'd2011 && job_n == 16'd3127)
        check("kat_2", 64'(rsp_m), 64'd2);
    end

    if (req_ready != '0) dut_log.push_back(req_ready);
    if (rsp_valid && rsp_ready && !rst) dut_hs++;
    if (core_start && !rst) begin
      lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, LAT_MAX));
      fin_pend = 1'b1;
      fin_cyc  = cyc + lat;
      fin_m    = modexp(core_c, core_d, core_n);
      if (job_act && cyc == job_L) begin
        job_lat  = lat;
        job_rise = job_L + ((CT && lat < int'(PAD)) ? int'(PAD) : lat) + 1;
        job_ovr  = CT && (lat > int'(PAD));
      end
    end
    if (rst) begin
      job_act = 1'b0;
      m_ptr   = 0;
    end else if (exp_rv && rsp_ready) begin
      mod_hs++;
      m_ptr   = (job_id + 1) % N;
      job_act = 1'b0;
    end else if (g >= 0) begin
      job_act  = 1'b1;
      job_id   = g;
      job_c    = rq_c[g];
      job_d    = rq_d[g];
      job_n    = rq_n[g];
      job_L    = cyc + 1;
      job_rise = NEVER;
      rq_v[g]  = 1'b0;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((job_act || rq_v != '0 || fin_pend) && k < budget) begin
      step();
      k++;
    end
    if (job_act || rq_v != '0 || fin_pend) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    repeat (2) step();
    rst_next = 1'b0;
    step();
  endtask

  initial begin
    int hs0, k;
    for (int i = 0; i < N; i++) begin
      rq_c[i] = '0; rq_d[i] = '0; rq_n[i] = 16'd3;
    end
    repeat (2) step();
    rst_next = 1'b0;
    step();

    // Single job from requester 0
    lat_force = 17;
    set_req(0, 16'd1394, 16'd2011, 16'd3127);
    run_until_idle(400);

    // Contention: all four at once after reset
    do_reset();
    dut_log.delete();
    lat_force = 0;
    set_req(0, 16'd1394, 16'd2011, 16'd3127);
    set_req(1, 16'd8, 16'd2011, 16'd3127);
    set_rand_req(2);
    set_rand_req(3);
    run_until_idle(2000);
    check("grant_cnt", 64'(dut_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < dut_log.size(); i++)
      check("grant_order", 64'(dut_log[i]), 64'(N'(1) << i));

    // Fairness: after serving 1, requester 3 beats requester 0
    dut_log.delete();
    set_rand_req(1);
    run_until_idle(400);
    set_rand_req(0);
    set_rand_req(3);
    run_until_idle(800);
    check("fair_cnt", 64'(dut_log.size()), 64'd3);
    if (dut_log.size() >= 3) begin
      check("fair_first", 64'(dut_log[1]), 64'b1000);
      check("fair_second", 64'(dut_log[2]), 64'b0001);
    end

    // Backpressure: 20 cycles of rsp_ready low, then exactly one response
    hs0 = dut_hs;
    bp_cnt = 20;
    set_rand_req(2);
    run_until_idle(400);
    check("bp_one_rsp", 64'(dut_hs - hs0), 64'd1);

    // Reset mid-BUSY, stray finish afterwards, then a normal job
    lat_force = 25;
    set_rand_req(1);
    k = 0;
    while (!(job_act && cyc >= job_L + 5) && k < 200) begin
      step();
      k++;
    end
    check("reached_busy", 64'(job_act), 64'd1);
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    hs0 = dut_hs;
    run_until_idle(100);
    check("no_rsp_after_abort", 64'(dut_hs - hs0), 64'd0);
    lat_force = 0;
    set_rand_req(3);
    run_until_idle(400);
    check("post_reset_rsp", 64'(dut_hs - hs0), 64'd1);

    // Latency corner jobs (padding below, at and beyond the window in CT mode)
    lat_force = 1;
    set_req(2, 16'd8, 16'd3, 16'd3127);
    run_until_idle(400);
    lat_force = 10;
    set_req(0, 16'd1394, 16'd2011, 16'd3127);
    run_until_idle(400);
    lat_force = CT ? int'(PAD) : 30;
    set_rand_req(1);
    run_until_idle(400);
    lat_force = CT ? 60 : 5;
    set_rand_req(3);
    run_until_idle(400);
    lat_force = 0;

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++)
        if (!rq_v[i] && $urandom_range(0, 7) == 0) set_rand_req(i);
      if ($urandom_range(0, 31) == 0) bp_cnt = int'($urandom_range(1, 8));
      step();
    end
    run_until_idle(3000);

    check("hs_count", 64'(dut_hs), 64'(mod_hs));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
